// File: rtl/misc_reg_write_arbiter.sv
// misc_reg_write_arbiter
// Owns the single write bus (strobes + W) into the TRISA/TRISB/OPTION block.
// After reset it plays a three-step boot load of default values. In RUN it
// arbitrates between core TRIS/OPTION decode and the host config port. The
// host is guaranteed a slot after STARVE_MAX consecutive core wins.
module misc_reg_write_arbiter #(
    parameter logic [3:0] TRISA_INIT  = 4'hF,
    parameter logic [7:0] TRISB_INIT  = 8'hFF,
    parameter logic [7:0] OPTION_INIT = 8'hFF,
    parameter int         STARVE_MAX  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       core_req,
    input  logic [1:0] core_sel,
    input  logic [7:0] core_data,
    output logic       core_stall,
    input  logic       host_valid,
    input  logic [1:0] host_addr,
    input  logic [7:0] host_data,
    output logic       host_ready,
    output logic       host_err,
    output logic       boot_done,
    output logic       TRISA_wr,
    output logic       TRISB_wr,
    output logic       OPTION_wr,
    output logic [7:0] W
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
    localparam logic [1:0]    SEL_NONE = 2'd3;

    typedef enum logic [1:0] {BOOT_A, BOOT_B, BOOT_O, RUN} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_starve;
    logic          r_trisa_wr, r_trisb_wr, r_option_wr, r_host_err, r_boot_done;
    logic [7:0]    r_w;

    logic       w_core_eff, w_forced, w_host_win, w_host_ready, w_core_stall;
    logic [1:0] w_wr_sel;
    logic [7:0] w_wr_data;

    // Sel 3 from the core is a no-op: it neither writes nor competes.
    assign w_core_eff = core_req & (core_sel != SEL_NONE);
    assign w_forced   = (r_starve == SMAX);

    // State register: reset restarts the boot sequence.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= BOOT_A;
        else      r_state <= w_state_nxt;
    end

    // Next state: boot steps advance unconditionally, RUN is terminal.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT_A:  w_state_nxt = BOOT_B;
            BOOT_B:  w_state_nxt = BOOT_O;
            BOOT_O:  w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Grant decode: picks the target register and data for next cycle's write.
    always_comb begin
        w_host_ready = 1'b0;
        w_host_win   = 1'b0;
        w_core_stall = 1'b0;
        w_wr_sel     = SEL_NONE;
        w_wr_data    = r_w;
        case (r_state)
            BOOT_A: begin
                w_core_stall = core_req;
                w_wr_sel     = 2'd0;
                w_wr_data    = {4'h0, TRISA_INIT};
            end
            BOOT_B: begin
                w_core_stall = core_req;
                w_wr_sel     = 2'd1;
                w_wr_data    = TRISB_INIT;
            end
            BOOT_O: begin
                w_core_stall = core_req;
                w_wr_sel     = 2'd2;
                w_wr_data    = OPTION_INIT;
            end
            default: begin
                // Host may go whenever the core is idle or has used up its run.
                w_host_ready = ~w_core_eff | w_forced;
                w_host_win   = host_valid & w_host_ready;
                w_core_stall = w_core_eff & w_host_win;
                if (w_host_win) begin
                    w_wr_sel  = host_addr;
                    w_wr_data = host_data;
                end else if (w_core_eff) begin
                    w_wr_sel  = core_sel;
                    w_wr_data = core_data;
                end
            end
        endcase
    end

    // Write bus register: one strobe per grant, W holds when nothing is written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_trisa_wr  <= 1'b0;
            r_trisb_wr  <= 1'b0;
            r_option_wr <= 1'b0;
            r_host_err  <= 1'b0;
            r_boot_done <= 1'b0;
            r_w         <= 8'h00;
        end else begin
            r_trisa_wr  <= (w_wr_sel == 2'd0);
            r_trisb_wr  <= (w_wr_sel == 2'd1);
            r_option_wr <= (w_wr_sel == 2'd2);
            r_host_err  <= w_host_win & (host_addr == SEL_NONE);
            r_boot_done <= r_boot_done | (r_state == BOOT_O);
            if (w_wr_sel != SEL_NONE) r_w <= w_wr_data;
        end
    end

    // Starvation counter: counts core wins over a waiting host, saturating.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (r_state == RUN) begin
            if (!host_valid || w_host_win)
                r_starve <= '0;
            else if (w_core_eff && !w_forced)
                r_starve <= r_starve + 1'b1;
        end
    end

    assign core_stall = w_core_stall;
    assign host_ready = w_host_ready;
    assign host_err   = r_host_err;
    assign boot_done  = r_boot_done;
    assign TRISA_wr   = r_trisa_wr;
    assign TRISB_wr   = r_trisb_wr;
    assign OPTION_wr  = r_option_wr;
    assign W          = r_w;

endmodule

// File: tb/tb_misc_reg_write_arbiter.sv
// Scoreboard bench for misc_reg_write_arbiter: the driver computes the
// expected next-cycle write bus from a behavioural model and queues it; a
// monitor pops and compares after every rising edge.
module tb_misc_reg_write_arbiter;

    localparam int         SM = 4;
    localparam logic [7:0] TA = 8'h0F;
    localparam logic [7:0] TB = 8'hFF;
    localparam logic [7:0] OP = 8'hFF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       core_req = 1'b0;
    logic [1:0] core_sel = 2'd0;
    logic [7:0] core_data = 8'h00;
    logic       core_stall;
    logic       host_valid = 1'b0;
    logic [1:0] host_addr = 2'd0;
    logic [7:0] host_data = 8'h00;
    logic       host_ready, host_err, boot_done;
    logic       TRISA_wr, TRISB_wr, OPTION_wr;
    logic [7:0] W;

    misc_reg_write_arbiter #(
        .TRISA_INIT(4'hF), .TRISB_INIT(8'hFF), .OPTION_INIT(8'hFF), .STARVE_MAX(SM)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_sel(core_sel), .core_data(core_data), .core_stall(core_stall),
        .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
        .host_ready(host_ready), .host_err(host_err), .boot_done(boot_done),
        .TRISA_wr(TRISA_wr), .TRISB_wr(TRISB_wr), .OPTION_wr(OPTION_wr), .W(W)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       a, b, o, err, bd;
        logic [7:0] w;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state: boot phase 0..2, 3 = running.
    int         phase = 0;
    int         cnt   = 0;
    logic [7:0] mw    = 8'h00;
    logic       mbd   = 1'b0;
    bit         mstall = 0;
    bit         mhr    = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, check the combinational handshake, queue
    // the expected registered outputs for the following edge.
    task automatic step(input logic r, input logic cr, input logic [1:0] cs, input logic [7:0] cd,
                        input logic hv, input logic [1:0] ha, input logic [7:0] hd);
        exp_t       e;
        bit         ce, hr, hw, st;
        logic [1:0] sel;
        logic [7:0] d;
        @(negedge clk);
        rst = r; core_req = cr; core_sel = cs; core_data = cd;
        host_valid = hv; host_addr = ha; host_data = hd;
        #1;
        e = '0; sel = 2'd3; d = mw; hr = 0; hw = 0; st = 0;
        if (!r) begin
            phase = 0; cnt = 0; mw = 8'h00; mbd = 1'b0;
        end else begin
            if (phase < 3) begin
                st  = cr;
                sel = 2'(phase);
                d   = (phase == 0) ? TA : (phase == 1) ? TB : OP;
                if (phase == 2) mbd = 1'b1;
                phase++;
            end else begin
                ce = cr && (cs != 2'd3);
                hr = !ce || (cnt == SM);
                hw = hv && hr;
                st = ce && hw;
                if (hw) begin
                    sel = ha; d = hd; e.err = (ha == 2'd3);
                end else if (ce) begin
                    sel = cs; d = cd;
                end
                if (!hv || hw) cnt = 0;
                else if (ce)   cnt = cnt + 1;
            end
            chk("host_ready", {7'd0, host_ready}, {7'd0, hr});
            chk("core_stall", {7'd0, core_stall}, {7'd0, st});
            e.a = (sel == 2'd0);
            e.b = (sel == 2'd1);
            e.o = (sel == 2'd2);
            if (sel != 2'd3) mw = d;
            e.w  = mw;
            e.bd = mbd;
        end
        mstall = st;
        mhr    = hr;
        q.push_back(e);
    endtask

    // Monitor: every edge that has a queued expectation gets compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("TRISA_wr",  {7'd0, TRISA_wr},  {7'd0, e.a});
                chk("TRISB_wr",  {7'd0, TRISB_wr},  {7'd0, e.b});
                chk("OPTION_wr", {7'd0, OPTION_wr}, {7'd0, e.o});
                chk("host_err",  {7'd0, host_err},  {7'd0, e.err});
                chk("boot_done", {7'd0, boot_done}, {7'd0, e.bd});
                chk("W", W, e.w);
            end
        end
    end

    initial begin
        logic       cr, hv;
        logic [1:0] cs, ha;
        logic [7:0] cd, hd;
        // Reset, then boot with both requesters knocking.
        repeat (3) step(0, 0, 0, 8'h00, 0, 0, 8'h00);
        step(1, 1, 1, 8'h11, 1, 0, 8'h22);
        step(1, 1, 1, 8'h11, 1, 0, 8'h22);
        step(1, 0, 0, 8'h00, 1, 0, 8'h22);
        // Host was valid across boot; let it go so core-only case is clean.
        step(1, 0, 0, 8'h00, 0, 0, 8'h00);
        // Core alone writes TRISB.
        step(1, 1, 1, 8'h5A, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00, 0, 0, 8'h00);
        // Sustained contention: core 4 wins then host, repeating.
        repeat (12) step(1, 1, 0, 8'h11, 1, 2, 8'h3C);
        step(1, 0, 0, 8'h00, 0, 0, 8'h00);
        // Host invalid address.
        step(1, 0, 0, 8'h00, 1, 3, 8'h77);
        step(1, 0, 0, 8'h00, 0, 0, 8'h00);
        // Core sel 3 does not block the host.
        step(1, 1, 3, 8'hEE, 1, 0, 8'h0A);
        step(1, 1, 3, 8'hEE, 0, 0, 8'h00);
        // Reset lands on a pending grant, then boot again.
        step(0, 1, 1, 8'hAB, 0, 0, 8'h00);
        repeat (5) step(1, 0, 0, 8'h00, 0, 0, 8'h00);

        // Randomised traffic; requesters hold while not taken.
        cr = 0; cs = 0; cd = 0; hv = 0; ha = 0; hd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!mstall) begin
                cr = ($urandom_range(0, 3) != 0);
                cs = 2'($urandom_range(0, 3));
                cd = 8'($urandom);
            end
            if (!(hv && !mhr)) begin
                hv = ($urandom_range(0, 2) != 0);
                ha = 2'($urandom_range(0, 3));
                hd = 8'($urandom);
            end
            step(($urandom_range(0, 99) != 0), cr, cs, cd, hv, ha, hd);
        end

        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
